// File: rtl/rr_arb3.sv
// rr_arb3: three-way round-robin arbiter with a registered one-hot grant.
// Define ARB_TIMEOUT_EN to add the hold-time watchdog (HOLD_W/MAX_HOLD).
module rr_arb3 #(
   parameter int HOLD_W   = 4,
   parameter int MAX_HOLD = 12
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] REQ,
   input  logic [2:0] DONE,
   output logic [2:0] GNT,
   output logic [1:0] GNT_ID,
   output logic       BUSY,
   output logic       TIMEOUT
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nxt;
   logic [2:0] gnt, gnt_nxt;
   logic [1:0] gnt_id, gnt_id_nxt;
   logic [1:0] last, last_nxt;
   logic [1:0] winner;
   logic       any_req;
   logic       owner_req, owner_done;
   logic       hold_expired;
   logic       release_now;

   if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_max_hold
      $error("rr_arb3: MAX_HOLD must be in 1..2**HOLD_W-1");
   end

   assign any_req = |REQ;

   // Grant is one-hot, so masking avoids indexing by the 2-bit id.
   assign owner_req  = |(REQ & gnt);
   assign owner_done = |(DONE & gnt);

   // Search order starts just after the last winner: LAST+1, LAST+2, LAST.
   always_comb begin
      winner = 2'd0;
      case (last)
         2'd0:    winner = REQ[1] ? 2'd1 : (REQ[2] ? 2'd2 : 2'd0);
         2'd1:    winner = REQ[2] ? 2'd2 : (REQ[0] ? 2'd0 : 2'd1);
         default: winner = REQ[0] ? 2'd0 : (REQ[1] ? 2'd1 : 2'd2);
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_cnt;
   logic              timeout_r;
   logic              timeout_nxt;

   assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   // A release that coincides with DONE or a dropped REQ is a normal one.
   assign timeout_nxt = (state == GRANT) && hold_expired && owner_req && !owner_done;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= timeout_nxt;
         if (state == IDLE)
            hold_cnt <= '0;
         else if (!release_now && hold_cnt != {HOLD_W{1'b1}})
            hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign TIMEOUT = timeout_r;
`else
   assign hold_expired = 1'b0;
   assign TIMEOUT      = 1'b0;
`endif

   assign release_now = owner_done || !owner_req || hold_expired;

   always_comb begin
      state_nxt  = state;
      gnt_nxt    = gnt;
      gnt_id_nxt = gnt_id;
      last_nxt   = last;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt  = GRANT;
               gnt_nxt    = 3'b001 << winner;
               gnt_id_nxt = winner;
               last_nxt   = winner;
            end
         end
         GRANT: begin
            // LAST is left alone here so rotation resumes from the owner.
            if (release_now) begin
               state_nxt  = IDLE;
               gnt_nxt    = 3'b000;
               gnt_id_nxt = 2'd0;
            end
         end
         default: begin
            state_nxt  = IDLE;
            gnt_nxt    = 3'b000;
            gnt_id_nxt = 2'd0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         gnt    <= 3'b000;
         gnt_id <= 2'd0;
         last   <= 2'd2;
      end else begin
         state  <= state_nxt;
         gnt    <= gnt_nxt;
         gnt_id <= gnt_id_nxt;
         last   <= last_nxt;
      end
   end

   assign GNT    = gnt;
   assign GNT_ID = gnt_id;
   assign BUSY   = |gnt;

endmodule

// File: tb/tb_rr_arb3.sv
// tb_rr_arb3: directed scenarios plus randomized traffic against a
// cycle-level reference model of the round-robin rules.
module tb_rr_arb3;

   localparam int HOLD_W   = 4;
   localparam int MAX_HOLD = 12;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] REQ, DONE;
   logic [2:0] GNT;
   logic [1:0] GNT_ID;
   logic       BUSY, TIMEOUT;

   int errors = 0;
   int checks = 0;

   // Model: owner (-1 = nobody), last winner, cycles the owner has held GNT.
   int   m_owner = -1;
   int   m_last  = 2;
   int   m_held  = 0;
   logic m_to    = 1'b0;

   always #5 CLK = ~CLK;

   rr_arb3 #(.HOLD_W(HOLD_W), .MAX_HOLD(MAX_HOLD)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .DONE(DONE),
      .GNT(GNT), .GNT_ID(GNT_ID), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
   );

   function automatic logic [2:0] m_gnt();
      return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
   endfunction

   function automatic logic [6:0] m_out();
      return {m_gnt(), (m_owner < 0) ? 2'd0 : 2'(m_owner), (m_owner >= 0), m_to};
   endfunction

   function automatic logic [6:0] dut_out();
      return {GNT, GNT_ID, BUSY, TIMEOUT};
   endfunction

   // Drive one cycle of inputs (called at negedge), advance the model, and
   // return at the following negedge so outputs are sampled mid-cycle.
   task automatic step(input logic rst, input logic [2:0] req, input logic [2:0] done);
      bit by_done, by_req, by_to;
      RST  = rst;
      REQ  = req;
      DONE = done;
      m_to = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_last  = 2;
         m_held  = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= 3; k++) begin
            if (req[(m_last + k) % 3]) begin
               m_owner = (m_last + k) % 3;
               m_last  = m_owner;
               m_held  = 1;
               break;
            end
         end
      end else begin
         by_done = done[m_owner];
         by_req  = !req[m_owner];
         by_to   = TO_EN && (m_held == MAX_HOLD);
         if (by_done || by_req || by_to) begin
            m_to    = by_to && !by_done && !by_req;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      step(1'b1, 3'b111, 3'b111);
      checks++;
      if (dut_out() !== 7'b000_00_0_0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", dut_out(), 7'b000_00_0_0);
      end
      step(1'b1, 3'b000, 3'b000);
      checks++;
      if (dut_out() !== m_out()) begin
         errors++;
         $display("FAIL reset_model got=%b exp=%b", dut_out(), m_out());
      end
   endtask

   task automatic test_rotation();
      logic [2:0] seq[$];
      logic [1:0] ids[$];
      logic [2:0] prev, d;
      logic [2:0] exp_g[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
      logic [1:0] exp_i[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
      step(1'b1, 3'b000, 3'b000);
      prev = 3'b000;
      for (int c = 0; c < 13; c++) begin
         d = (m_owner >= 0 && m_held == 2) ? m_gnt() : 3'b000;
         step(1'b0, 3'b111, d);
         checks++;
         if (dut_out() !== m_out()) begin
            errors++;
            $display("FAIL rotation_cyc%0d got=%b exp=%b", c, dut_out(), m_out());
         end
         if (GNT !== 3'b000 && prev === 3'b000) begin
            seq.push_back(GNT);
            ids.push_back(GNT_ID);
         end
         prev = GNT;
      end
      checks++;
      if (seq.size() < 4) begin
         errors++;
         $display("FAIL rotation_count got=%0d exp>=4", seq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] !== exp_g[i] || ids[i] !== exp_i[i]) begin
               errors++;
               $display("FAIL rotation_order%0d got=%b/%0d exp=%b/%0d", i, seq[i], ids[i], exp_g[i], exp_i[i]);
            end
         end
      end
   endtask

   task automatic test_last_priority();
      step(1'b1, 3'b000, 3'b000);
      step(1'b0, 3'b010, 3'b000);
      step(1'b0, 3'b010, 3'b010);
      step(1'b0, 3'b101, 3'b000);
      checks++;
      if (GNT !== 3'b100 || GNT_ID !== 2'd2 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL last_prio_first got=%b exp=%b", dut_out(), m_out());
      end
      step(1'b0, 3'b101, 3'b100);
      checks++;
      if (GNT !== 3'b000 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL last_prio_gap got=%b exp=%b", dut_out(), m_out());
      end
      step(1'b0, 3'b101, 3'b000);
      checks++;
      if (GNT !== 3'b001 || GNT_ID !== 2'd0 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL last_prio_second got=%b exp=%b", dut_out(), m_out());
      end
   endtask

   task automatic test_nonowner_done();
      step(1'b1, 3'b000, 3'b000);
      step(1'b0, 3'b001, 3'b000);
      checks++;
      if (GNT !== 3'b001) begin
         errors++;
         $display("FAIL nonowner_grant got=%b exp=001", GNT);
      end
      step(1'b0, 3'b001, 3'b010);
      checks++;
      if (GNT !== 3'b001 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL nonowner_done got=%b exp=%b", dut_out(), m_out());
      end
      step(1'b0, 3'b000, 3'b000);
      checks++;
      if (GNT !== 3'b000 || BUSY !== 1'b0 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL nonowner_reqdrop got=%b exp=%b", dut_out(), m_out());
      end
   endtask

   task automatic test_timeout();
      logic [2:0] g[20];
      logic       t[20];
      int         held;
      step(1'b1, 3'b000, 3'b000);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 3'b001, 3'b000);
         g[i] = GNT;
         t[i] = TIMEOUT;
         checks++;
         if (dut_out() !== m_out()) begin
            errors++;
            $display("FAIL timeout_cyc%0d got=%b exp=%b", i, dut_out(), m_out());
         end
      end
      held = 0;
      for (int i = 0; i < 20 && g[i] === 3'b001; i++) held++;
      checks++;
      if (TO_EN) begin
         if (held != MAX_HOLD || g[12] !== 3'b000 || t[12] !== 1'b1 || t[11] !== 1'b0 ||
             g[13] !== 3'b001 || t[13] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_shape got held=%0d g12=%b t12=%b g13=%b t13=%b exp held=%0d 000 1 001 0",
                     held, g[12], t[12], g[13], t[13], MAX_HOLD);
         end
      end else begin
         if (held != 20 || t.or() !== 1'b0) begin
            errors++;
            $display("FAIL timeout_absent got held=%0d anyto=%b exp held=20 anyto=0", held, t.or());
         end
      end
   endtask

   task automatic test_mid_reset();
      step(1'b1, 3'b000, 3'b000);
      step(1'b0, 3'b010, 3'b000);
      step(1'b0, 3'b010, 3'b000);
      checks++;
      if (GNT !== 3'b010) begin
         errors++;
         $display("FAIL midrst_pre got=%b exp=010", GNT);
      end
      step(1'b1, 3'b111, 3'b000);
      checks++;
      if (GNT !== 3'b000 || BUSY !== 1'b0 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL midrst_clear got=%b exp=%b", dut_out(), m_out());
      end
      step(1'b0, 3'b111, 3'b000);
      checks++;
      if (GNT !== 3'b001 || GNT_ID !== 2'd0 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL midrst_first got=%b exp=%b", dut_out(), m_out());
      end
   endtask

   task automatic test_one_cycle_req();
      step(1'b1, 3'b000, 3'b000);
      step(1'b0, 3'b010, 3'b000);
      checks++;
      if (GNT !== 3'b010 || GNT_ID !== 2'd1 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL onecyc_grant got=%b exp=%b", dut_out(), 7'b010_01_1_0);
      end
      step(1'b0, 3'b000, 3'b000);
      checks++;
      if (GNT !== 3'b000 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL onecyc_release got=%b exp=%b", dut_out(), m_out());
      end
      step(1'b0, 3'b000, 3'b111);
      checks++;
      if (GNT !== 3'b000 || dut_out() !== m_out()) begin
         errors++;
         $display("FAIL onecyc_idle_done got=%b exp=%b", dut_out(), m_out());
      end
   endtask

   task automatic test_random();
      logic [2:0] req, done;
      logic       rst;
      int         prev_owner;
      int         waits[3];
      req = 3'b000;
      step(1'b1, 3'b000, 3'b000);
      for (int i = 0; i < 3; i++) waits[i] = 0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) req = 3'($urandom);
         done = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
         rst  = ($urandom_range(0, 149) == 0);
         prev_owner = m_owner;
         step(rst, req, done);
         checks++;
         if (dut_out() !== m_out()) begin
            errors++;
            $display("FAIL random_cyc%0d got=%b exp=%b", c, dut_out(), m_out());
         end
         checks++;
         if ($countones(GNT) > 1 || (GNT != 3'b000 && GNT !== 3'(1 << GNT_ID)) ||
             (GNT == 3'b000 && GNT_ID != 2'd0) || BUSY !== (|GNT)) begin
            errors++;
            $display("FAIL random_onehot_cyc%0d got gnt=%b id=%0d busy=%b", c, GNT, GNT_ID, BUSY);
         end
         if (rst) begin
            for (int i = 0; i < 3; i++) waits[i] = 0;
         end else if (prev_owner < 0 && m_owner >= 0) begin
            for (int i = 0; i < 3; i++) begin
               if (i == m_owner) begin
                  waits[i] = 0;
               end else if (req[i]) begin
                  waits[i]++;
                  checks++;
                  if (waits[i] > 2) begin
                     errors++;
                     $display("FAIL starvation_req%0d got=%0d other grants exp<=2", i, waits[i]);
                  end
               end
            end
         end
         for (int i = 0; i < 3; i++) if (!req[i]) waits[i] = 0;
      end
   endtask

   initial begin
      RST  = 1'b1;
      REQ  = 3'b000;
      DONE = 3'b000;
      @(negedge CLK);
      test_reset();
      test_rotation();
      test_last_priority();
      test_nonowner_done();
      test_timeout();
      test_mid_reset();
      test_one_cycle_req();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
